sa_matmul_seq: RTL and testbench
================================

# sa_matmul_seq

Parametrised tile sequencer for the systolic matmul datapath. It generalises the fixed single-pass controller: it runs a runtime-selected number of K-tiles (`i_num_tiles`) over a runtime-selected number of activation rows (`i_m_rows`). Partial sums are accumulated across tiles through a read/write output memory. It sits between the input, weight and output `mem_simple` instances and `sa_compute`. It drives only memory control, addresses and compute mode; no data passes through it.

## Interface
- `NUM_ROWS`, 4, array rows; also the number of weight rows per tile.
- `NUM_COLS`, 4, array columns.
- `MEM_ROWS`, 16, depth of each memory.
- `MAX_TILES`, 4, maximum K-tiles per job.
- `PIPE_LAT`, `NUM_ROWS+NUM_COLS`, cycles from an input address being issued to the output-write address for that row.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `i_start`  in  1  job request; sampled only in IDLE.
- `i_num_tiles`  in  `$clog2(MAX_TILES+1)`  K-tiles; sampled with start.
- `i_m_rows`  in  `$clog2(MEM_ROWS+1)`  activation rows per tile; sampled with start.
- `o_busy`  out  1  high from the cycle after start is accepted until done.
- `o_done`  out  1  one-cycle completion pulse.
- `o_err`  out  1  one-cycle pulse, coincident with `o_done`, on a rejected job.
- `o_weight_cenb`, `o_input_cenb`  out  1  active-low read selects.
- `o_weight_addr`, `o_input_addr`  out  `$clog2(MEM_ROWS)`  read addresses.
- `o_psum_cenb`  out  1  active-low output-memory read select.
- `o_psum_addr`  out  `$clog2(MEM_ROWS)`  output-memory read address.
- `o_output_cenb`, `o_output_wenb`  out  1  active-low output-memory write select/enable.
- `o_output_addr`  out  `$clog2(MEM_ROWS)`  output-memory write address.
- `o_mode`  out  1  1 = weight preload into the array, 0 = compute.
- `o_load_psum`  out  1  1 = array adds incoming psum (tiles after the first).

## Operation
- **Reset values:** all `*cenb`/`*wenb` = 1; all addresses = 0; `o_mode`, `o_load_psum`, `o_busy`, `o_done`, `o_err` = 0; FSM in IDLE.
- **States:** IDLE → LOAD_W → STREAM → DRAIN → (LOAD_W for the next tile | DONE) → IDLE.
- **Memory layout for tile t (0-based):**
  - weight rows `t*NUM_ROWS .. t*NUM_ROWS+NUM_ROWS-1`;
  - input rows `t*M .. t*M+M-1`;
  - output rows `0..M-1`, shared by all tiles.
- **LOAD_W:** `NUM_ROWS` cycles, one weight address per cycle, ascending.
- **STREAM:** M cycles, one input address per cycle, ascending. For tile > 0, `o_psum_addr` = row r is issued in the same cycle as input row r.
- **DRAIN:** holds until the last output write of the tile is issued.
- **Output write:** for row r, `o_output_cenb`/`o_output_wenb` = 0 and `o_output_addr` = r, exactly `PIPE_LAT` cycles after input row r is issued.
- **Address arithmetic:** a running base register, with no multiplier. Addresses never wrap; legality is checked at start.
- **Rejected job:** if `i_num_tiles` = 0, or `i_m_rows` = 0, or `i_num_tiles > MAX_TILES`, or `i_num_tiles*i_m_rows > MEM_ROWS`, or `i_num_tiles*NUM_ROWS > MEM_ROWS`: no memory access occurs, `o_done` and `o_err` pulse on the cycle after start, and the FSM returns to IDLE.
- **`i_start` while busy:** ignored, with no queueing.
- **`i_start` in the DONE cycle:** ignored. A new job is accepted only once the FSM is back in IDLE.

## Timing
- Memory read latency is 1 cycle.
  - `o_mode` = registered copy of the weight read select, so it is high exactly while weight data is valid.
  - `o_load_psum` = registered copy of the psum read select.
- **Cycle numbering:** start is sampled at cycle 0 and the first weight address is issued at cycle 1.
- **Tile length:** `NUM_ROWS + M + PIPE_LAT` cycles. The next tile's first weight address follows the previous tile's last output write by one cycle.
- **Done:** `o_done` fires one cycle after the final output write, at cycle `1 + T*(NUM_ROWS+M+PIPE_LAT)`. `o_busy` falls in that same cycle.
- **Reset mid-job:** all outputs return to reset values asynchronously. Memory contents are undefined-but-untouched, and there is no done pulse.

## Structure
- **`sa_pkg`:** `seq_state_t` enum; the rejection-condition function.
- **`sa_delay_line`** (sub-module): depth `PIPE_LAT`, carries a valid bit plus a row address. It generates the output-write timing and the completion/drain detect; its valid is cleared on reset.
- **Main block:** FSM, tile and row counters, base-address registers.

## Test plan
- NUM_ROWS=4, PIPE_LAT=8, T=1, M=4 → weight addresses 0..3 at cycles 1–4; input addresses 0..3 at cycles 5–8; writes to 0..3 at cycles 13–16; `o_done` at cycle 17; `o_load_psum` never set.
- T=2, M=4 → second tile weight addresses 4..7 and input addresses 4..7; psum reads 0..3 coincide with the input reads; `o_load_psum` high at cycles 22–25; `o_done` at cycle 33.
- T=0; separately T=3, M=6 → `o_done` and `o_err` at cycle 1; no `cenb` ever low.
- `i_start` pulsed at cycle 10 of a running job → schedule unchanged, single `o_done`.
- `rst_n` low at cycle 9 → all outputs at reset values immediately; a new start after release runs a clean job.
- Boundary fill: T=4, M=4, MEM_ROWS=16 → last weight and input addresses are 15; no wrap; `o_err` = 0.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and job-legality check for the systolic matmul tile sequencer.
package sa_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } seq_state_t;

  // A job is refused up front so that no address ever has to wrap.
  function automatic logic job_reject(input int nt, input int m, input int max_tiles,
                                      input int mem_rows, input int num_rows);
    return (nt == 0) || (m == 0) || (nt > max_tiles) ||
           (nt * m > mem_rows) || (nt * num_rows > mem_rows);
  endfunction

endpackage

// File: rtl/sa_delay_line.sv
// Fixed-depth shift line carrying a valid flag and a row address; sets output-write timing.
module sa_delay_line #(
  parameter int DEPTH = 8,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  input  logic [AW-1:0] i_addr,
  output logic          o_vld,
  output logic [AW-1:0] o_addr
);

  logic [DEPTH-1:0]         r_vld;
  logic [DEPTH-1:0][AW-1:0] r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_addr <= '0;
    end else begin
      r_vld[0]  <= i_vld;
      r_addr[0] <= i_addr;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_addr[i] <= r_addr[i-1];
      end
    end
  end

  assign o_vld  = r_vld[DEPTH-1];
  assign o_addr = r_addr[DEPTH-1];

endmodule

// File: rtl/sa_matmul_seq.sv
// Multi-tile sequencer: issues weight/input/psum reads and output writes for T K-tiles of M rows.
module sa_matmul_seq
  import sa_pkg::*;
#(
  parameter int NUM_ROWS  = 4,
  parameter int NUM_COLS  = 4,
  parameter int MEM_ROWS  = 16,
  parameter int MAX_TILES = 4,
  parameter int PIPE_LAT  = NUM_ROWS + NUM_COLS,
  localparam int NT_W = $clog2(MAX_TILES + 1),
  localparam int MR_W = $clog2(MEM_ROWS + 1),
  localparam int AW   = $clog2(MEM_ROWS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [NT_W-1:0] i_num_tiles,
  input  logic [MR_W-1:0] i_m_rows,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err,
  output logic            o_weight_cenb,
  output logic            o_input_cenb,
  output logic [AW-1:0]   o_weight_addr,
  output logic [AW-1:0]   o_input_addr,
  output logic            o_psum_cenb,
  output logic [AW-1:0]   o_psum_addr,
  output logic            o_output_cenb,
  output logic            o_output_wenb,
  output logic [AW-1:0]   o_output_addr,
  output logic            o_mode,
  output logic            o_load_psum
);

  localparam logic [AW-1:0] NR_LAST = AW'(NUM_ROWS - 1);

  seq_state_t      r_state, w_next;
  logic [NT_W-1:0] r_nt, r_tile;
  logic [AW-1:0]   r_m_last, r_row, r_waddr, r_iaddr;
  logic            r_err, r_mode, r_load_psum;
  logic            w_reject, w_dl_vld, w_last_wr, w_last_tile;
  logic [AW-1:0]   w_dl_addr;

  assign w_reject    = job_reject(int'(i_num_tiles), int'(i_m_rows), MAX_TILES, MEM_ROWS, NUM_ROWS);
  assign w_last_wr   = w_dl_vld && (w_dl_addr == r_m_last);
  assign w_last_tile = (r_tile == r_nt - NT_W'(1));

  sa_delay_line #(.DEPTH(PIPE_LAT), .AW(AW)) u_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_vld  (r_state == S_STREAM),
    .i_addr (r_row),
    .o_vld  (w_dl_vld),
    .o_addr (w_dl_addr)
  );

  always_comb begin
    w_next        = r_state;
    o_weight_cenb = 1'b1;
    o_input_cenb  = 1'b1;
    o_psum_cenb   = 1'b1;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    o_err         = 1'b0;
    case (r_state)
      S_IDLE:   if (i_start) w_next = w_reject ? S_DONE : S_LOAD_W;
      S_LOAD_W: begin
        o_weight_cenb = 1'b0;
        o_busy        = 1'b1;
        if (r_row == NR_LAST) w_next = S_STREAM;
      end
      S_STREAM: begin
        o_input_cenb = 1'b0;
        o_psum_cenb  = (r_tile == '0);
        o_busy       = 1'b1;
        if (r_row == r_m_last) w_next = S_DRAIN;
      end
      // Wait for the pipeline to deliver the tile's final row to the output memory.
      S_DRAIN: begin
        o_busy = 1'b1;
        if (w_last_wr) w_next = w_last_tile ? S_DONE : S_LOAD_W;
      end
      S_DONE: begin
        o_done = 1'b1;
        o_err  = r_err;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_nt        <= '0;
      r_tile      <= '0;
      r_m_last    <= '0;
      r_row       <= '0;
      r_waddr     <= '0;
      r_iaddr     <= '0;
      r_err       <= 1'b0;
      r_mode      <= 1'b0;
      r_load_psum <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_mode      <= !o_weight_cenb;
      r_load_psum <= !o_psum_cenb;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_nt     <= i_num_tiles;
          r_m_last <= AW'(i_m_rows - MR_W'(1));
          r_err    <= w_reject;
          r_tile   <= '0;
          r_row    <= '0;
          r_waddr  <= '0;
          r_iaddr  <= '0;
        end
        // Weight and input tiles are contiguous, so running addresses replace t*NUM_ROWS / t*M.
        S_LOAD_W: begin
          r_waddr <= r_waddr + AW'(1);
          r_row   <= (r_row == NR_LAST) ? '0 : r_row + AW'(1);
        end
        S_STREAM: begin
          r_iaddr <= r_iaddr + AW'(1);
          r_row   <= (r_row == r_m_last) ? '0 : r_row + AW'(1);
        end
        S_DRAIN: if (w_last_wr && !w_last_tile) r_tile <= r_tile + NT_W'(1);
        default: ;
      endcase
    end
  end

  assign o_psum_addr   = r_row;
  assign o_weight_addr = r_waddr;
  assign o_input_addr  = r_iaddr;
  assign o_output_cenb = !w_dl_vld;
  assign o_output_wenb = !w_dl_vld;
  assign o_output_addr = w_dl_addr;
  assign o_mode        = r_mode;
  assign o_load_psum   = r_load_psum;

endmodule

// File: tb/tb_sa_matmul_seq.sv
// Directed bench for sa_matmul_seq: traces each job cycle by cycle and checks hand-derived schedules.
module tb_sa_matmul_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [2:0] i_num_tiles = '0;
  logic [4:0] i_m_rows = '0;
  logic       o_busy, o_done, o_err;
  logic       o_weight_cenb, o_input_cenb, o_psum_cenb;
  logic [3:0] o_weight_addr, o_input_addr, o_psum_addr, o_output_addr;
  logic       o_output_cenb, o_output_wenb, o_mode, o_load_psum;

  sa_matmul_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_num_tiles   (i_num_tiles),
    .i_m_rows      (i_m_rows),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err),
    .o_weight_cenb (o_weight_cenb),
    .o_input_cenb  (o_input_cenb),
    .o_weight_addr (o_weight_addr),
    .o_input_addr  (o_input_addr),
    .o_psum_cenb   (o_psum_cenb),
    .o_psum_addr   (o_psum_addr),
    .o_output_cenb (o_output_cenb),
    .o_output_wenb (o_output_wenb),
    .o_output_addr (o_output_addr),
    .o_mode        (o_mode),
    .o_load_psum   (o_load_psum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] tw_cen[0:79], tw_adr[0:79], ti_cen[0:79], ti_adr[0:79];
  logic [31:0] tp_cen[0:79], tp_adr[0:79], to_cen[0:79], to_wen[0:79], to_adr[0:79];
  logic [31:0] t_mode[0:79], t_lps[0:79], t_busy[0:79], t_done[0:79], t_err[0:79];
  int n_w, n_i, n_p, n_o, n_lps, n_done, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample();
    tw_cen[cyc] = 32'(o_weight_cenb); tw_adr[cyc] = 32'(o_weight_addr);
    ti_cen[cyc] = 32'(o_input_cenb);  ti_adr[cyc] = 32'(o_input_addr);
    tp_cen[cyc] = 32'(o_psum_cenb);   tp_adr[cyc] = 32'(o_psum_addr);
    to_cen[cyc] = 32'(o_output_cenb); to_wen[cyc] = 32'(o_output_wenb);
    to_adr[cyc] = 32'(o_output_addr);
    t_mode[cyc] = 32'(o_mode); t_lps[cyc] = 32'(o_load_psum);
    t_busy[cyc] = 32'(o_busy); t_done[cyc] = 32'(o_done); t_err[cyc] = 32'(o_err);
  endtask

  task automatic start_job(input int nt, input int m);
    @(negedge clk);
    i_start = 1'b1;
    i_num_tiles = 3'(nt);
    i_m_rows = 5'(m);
    cyc = 0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    i_start = 1'b0;
    cyc++;
    sample();
  endtask

  task automatic run_to(input int last);
    while (cyc < last) next_cycle();
  endtask

  task automatic count_job();
    n_w = 0; n_i = 0; n_p = 0; n_o = 0; n_lps = 0; n_done = 0; n_err = 0;
    for (int i = 1; i <= cyc; i++) begin
      if (tw_cen[i] == 0) n_w++;
      if (ti_cen[i] == 0) n_i++;
      if (tp_cen[i] == 0) n_p++;
      if (to_cen[i] == 0) n_o++;
      if (t_lps[i] == 1) n_lps++;
      if (t_done[i] == 1) n_done++;
      if (t_err[i] == 1) n_err++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wcen"}, 32'(o_weight_cenb), 1);
    chk({tag, "_icen"}, 32'(o_input_cenb), 1);
    chk({tag, "_pcen"}, 32'(o_psum_cenb), 1);
    chk({tag, "_ocen"}, 32'(o_output_cenb), 1);
    chk({tag, "_owen"}, 32'(o_output_wenb), 1);
    chk({tag, "_addrs"}, 32'({o_weight_addr, o_input_addr, o_psum_addr, o_output_addr}), 0);
    chk({tag, "_ctl"}, 32'({o_mode, o_load_psum, o_busy, o_done, o_err}), 0);
  endtask

  initial begin
    // Reset state
    #12;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Single tile, M=4
    start_job(1, 4);
    run_to(20);
    chk("t1_w1_cen", tw_cen[1], 0);   chk("t1_w1_adr", tw_adr[1], 0);
    chk("t1_w4_adr", tw_adr[4], 3);   chk("t1_w5_cen", tw_cen[5], 1);
    chk("t1_i5_cen", ti_cen[5], 0);   chk("t1_i5_adr", ti_adr[5], 0);
    chk("t1_i8_adr", ti_adr[8], 3);   chk("t1_i9_cen", ti_cen[9], 1);
    chk("t1_mode1", t_mode[1], 0);    chk("t1_mode2", t_mode[2], 1);
    chk("t1_mode5", t_mode[5], 1);    chk("t1_mode6", t_mode[6], 0);
    chk("t1_o12_cen", to_cen[12], 1); chk("t1_o13_cen", to_cen[13], 0);
    chk("t1_o13_wen", to_wen[13], 0); chk("t1_o13_adr", to_adr[13], 0);
    chk("t1_o16_adr", to_adr[16], 3); chk("t1_o17_cen", to_cen[17], 1);
    chk("t1_busy1", t_busy[1], 1);    chk("t1_busy16", t_busy[16], 1);
    chk("t1_busy17", t_busy[17], 0);  chk("t1_done16", t_done[16], 0);
    chk("t1_done17", t_done[17], 1);  chk("t1_err17", t_err[17], 0);
    count_job();
    chk("t1_n_w", n_w, 4);   chk("t1_n_i", n_i, 4);   chk("t1_n_o", n_o, 4);
    chk("t1_n_p", n_p, 0);   chk("t1_n_lps", n_lps, 0); chk("t1_n_done", n_done, 1);

    // Two tiles, M=4: psum accumulation on the second tile
    start_job(2, 4);
    run_to(36);
    chk("t2_o16_adr", to_adr[16], 3); chk("t2_w16_cen", tw_cen[16], 1);
    chk("t2_w17_cen", tw_cen[17], 0); chk("t2_w17_adr", tw_adr[17], 4);
    chk("t2_w20_adr", tw_adr[20], 7); chk("t2_i21_adr", ti_adr[21], 4);
    chk("t2_i24_adr", ti_adr[24], 7); chk("t2_p21_cen", tp_cen[21], 0);
    chk("t2_p21_adr", tp_adr[21], 0); chk("t2_p24_adr", tp_adr[24], 3);
    chk("t2_lps21", t_lps[21], 0);    chk("t2_lps22", t_lps[22], 1);
    chk("t2_lps25", t_lps[25], 1);    chk("t2_lps26", t_lps[26], 0);
    chk("t2_o29_adr", to_adr[29], 0); chk("t2_o32_adr", to_adr[32], 3);
    chk("t2_busy32", t_busy[32], 1);  chk("t2_done33", t_done[33], 1);
    count_job();
    chk("t2_n_w", n_w, 8);   chk("t2_n_i", n_i, 8);   chk("t2_n_p", n_p, 4);
    chk("t2_n_lps", n_lps, 4); chk("t2_n_o", n_o, 8); chk("t2_n_done", n_done, 1);

    // Rejected jobs: zero tiles, then a job that overflows the input memory
    start_job(0, 4);
    run_to(4);
    chk("r0_done1", t_done[1], 1); chk("r0_err1", t_err[1], 1);
    chk("r0_busy1", t_busy[1], 0); chk("r0_done2", t_done[2], 0);
    count_job();
    chk("r0_n_mem", n_w + n_i + n_p + n_o, 0);
    start_job(3, 6);
    run_to(4);
    chk("r1_done1", t_done[1], 1); chk("r1_err1", t_err[1], 1);
    count_job();
    chk("r1_n_mem", n_w + n_i + n_p + n_o, 0); chk("r1_n_done", n_done, 1);

    // Start re-pulsed while running and again in the DONE cycle
    start_job(1, 4);
    run_to(10);
    i_start = 1'b1;
    run_to(17);
    i_start = 1'b1;
    run_to(21);
    chk("sb_o16_adr", to_adr[16], 3); chk("sb_done17", t_done[17], 1);
    chk("sb_busy18", t_busy[18], 0);  chk("sb_w18_cen", tw_cen[18], 1);
    count_job();
    chk("sb_n_w", n_w, 4); chk("sb_n_done", n_done, 1);

    // Reset mid-job, then a clean job
    start_job(1, 4);
    run_to(8);
    chk("mr_i8_adr", ti_adr[8], 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mr");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_job(1, 4);
    run_to(18);
    chk("mr_o13_adr", to_adr[13], 0); chk("mr_done17", t_done[17], 1);
    count_job();
    chk("mr_n_o", n_o, 4); chk("mr_n_done", n_done, 1);

    // Boundary fill: four tiles of four rows use every memory row
    start_job(4, 4);
    run_to(68);
    chk("bf_w52_adr", tw_adr[52], 15); chk("bf_i56_adr", ti_adr[56], 15);
    chk("bf_o64_adr", to_adr[64], 3);  chk("bf_done65", t_done[65], 1);
    chk("bf_err65", t_err[65], 0);
    count_job();
    chk("bf_n_w", n_w, 16); chk("bf_n_i", n_i, 16); chk("bf_n_p", n_p, 12);
    chk("bf_n_o", n_o, 16); chk("bf_n_err", n_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
